// File: rtl/nibble_serial_add_sched.sv
// Two-requester WIDTH-bit adder that time-shares one 4-bit ripple stage,
// one nibble per cycle LSB first, with round-robin grant and a valid/ready response.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module nibble_serial_add_sched #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("nibble_serial_add_sched: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic             last_grant;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [3:0]       nib_sum;
    logic [4:0]       c;
    logic             winner;
    logic             accept;

    // winner is only meaningful when at least one request is valid
    always_comb begin
        winner     = (req0_valid & req1_valid) ? ~last_grant : ~req0_valid;
        req0_ready = (state == IDLE) & req0_valid & ~winner;
        req1_ready = (state == IDLE) & req1_valid & winner;
        accept     = req0_ready | req1_ready;
    end

    assign c[0] = carry;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        full_adder u_fa (
            .a    (a_sh[i]),
            .b    (b_sh[i]),
            .cin  (c[i]),
            .s    (nib_sum[i]),
            .cout (c[i+1])
        );
    end

    // new nibble enters at the top so the LSB nibble ends at bit 0 after NIB steps
    always_comb begin
        res_next                = res >> 4;
        res_next[WIDTH-1 -: 4]  = nib_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rsp_valid  <= 1'b0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            carry      <= 1'b0;
            a_sh       <= '0;
            b_sh       <= '0;
            res        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh       <= winner ? req1_a : req0_a;
                        b_sh       <= winner ? req1_b : req0_b;
                        carry      <= winner ? req1_cin : req0_cin;
                        rsp_id     <= winner;
                        last_grant <= winner;
                        cnt        <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    res   <= res_next;
                    carry <= c[4];
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(NIB - 1)) begin
                        rsp_sum   <= res_next;
                        rsp_cout  <= c[4];
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_sched.sv
// Scoreboard bench: one WIDTH=16 lane with directed cases plus random traffic,
// one WIDTH=4 lane with random traffic, both checked against A+B+cin arithmetic.

module tb_nibble_serial_add_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc    = 0;
    logic [1:0]  done   = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int W = (g == 0) ? 16 : 4;
        localparam int N = W / 4;

        typedef struct {
            logic [W-1:0] s;
            logic         c;
            logic         id;
        } exp_t;

        logic         rst = 1'b1;
        logic         r0v = 1'b0, r0c = 1'b0, r1v = 1'b0, r1c = 1'b0, rspr = 1'b0;
        logic [W-1:0] r0a = '0, r0b = '0, r1a = '0, r1b = '0;
        logic         r0r, r1r, rv, rc, rid;
        logic [W-1:0] rs;

        exp_t        sb[$];
        int unsigned acc_edge[$];
        logic        acc_id[$];
        int unsigned nacc = 0;

        nibble_serial_add_sched #(.WIDTH(W)) dut (
            .clk        (clk),
            .rst        (rst),
            .req0_valid (r0v),
            .req0_ready (r0r),
            .req0_a     (r0a),
            .req0_b     (r0b),
            .req0_cin   (r0c),
            .req1_valid (r1v),
            .req1_ready (r1r),
            .req1_a     (r1a),
            .req1_b     (r1b),
            .req1_cin   (r1c),
            .rsp_valid  (rv),
            .rsp_ready  (rspr),
            .rsp_sum    (rs),
            .rsp_cout   (rc),
            .rsp_id     (rid)
        );

        // monitor: reference model of grant order and busy span, plus the response scoreboard
        initial begin
            logic        busy;
            logic        lastg;
            logic        rv_prev;
            logic        win;
            logic        id;
            logic [W:0]  full;
            int unsigned last_acc;
            exp_t        e;
            busy = 1'b0; lastg = 1'b1; rv_prev = 1'b0; last_acc = 0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    sb.delete();
                    busy = 1'b0; lastg = 1'b1; rv_prev = 1'b0;
                end else begin
                    chk("both_ready", {31'b0, r0r & r1r}, 32'd0);
                    if (busy) begin
                        chk("ready_while_busy", {30'b0, r0r, r1r}, 32'd0);
                    end else if (r0v | r1v) begin
                        win = (r0v & r1v) ? ~lastg : ~r0v;
                        chk("grant", {30'b0, r0r, r1r}, win ? 32'd1 : 32'd2);
                    end
                    if (rv) begin
                        if (sb.size() == 0) begin
                            chk("rsp_unexpected", 32'd1, 32'd0);
                        end else begin
                            chk("rsp_sum", 32'(rs), 32'(sb[0].s));
                            chk("rsp_cout", {31'b0, rc}, {31'b0, sb[0].c});
                            chk("rsp_id", {31'b0, rid}, {31'b0, sb[0].id});
                            if (!rv_prev) chk("latency", cyc - last_acc, N);
                            if (rspr) begin
                                void'(sb.pop_front());
                                busy = 1'b0;
                            end
                        end
                    end
                    if ((r0v & r0r) | (r1v & r1r)) begin
                        id   = r1v & r1r;
                        full = id ? ({1'b0, r1a} + {1'b0, r1b} + (W+1)'(r1c))
                                  : ({1'b0, r0a} + {1'b0, r0b} + (W+1)'(r0c));
                        e.s  = full[W-1:0];
                        e.c  = full[W];
                        e.id = id;
                        sb.push_back(e);
                        acc_edge.push_back(cyc + 1);
                        acc_id.push_back(id);
                        nacc++;
                        last_acc = cyc + 1;
                        lastg    = id;
                        busy     = 1'b1;
                    end
                    rv_prev = rv;
                end
            end
        end

        task automatic do_reset();
            @(posedge clk); #1;
            rst = 1'b1; r0v = 1'b0; r1v = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
        endtask

        task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin);
            bit ok;
            @(posedge clk); #1;
            if (id) begin r1v = 1'b1; r1a = a; r1b = b; r1c = cin; end
            else    begin r0v = 1'b1; r0a = a; r0b = b; r0c = cin; end
            ok = 1'b0;
            for (int i = 0; i < 40 && !ok; i++) begin
                @(negedge clk);
                ok = id ? r1r : r0r;
            end
            if (!ok) chk("issue_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
            if (id) r1v = 1'b0; else r0v = 1'b0;
        endtask

        task automatic wait_rsp(input logic [W-1:0] s, input logic c, input logic id);
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 40 && !ok; i++) begin
                @(negedge clk);
                ok = rv;
            end
            chk("wait_rsp", {31'b0, ok}, 32'd1);
            chk("dir_sum", 32'(rs), 32'(s));
            chk("dir_cout", {31'b0, rc}, {31'b0, c});
            chk("dir_id", {31'b0, rid}, {31'b0, id});
        endtask

        task automatic wait_acc(input int unsigned n);
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 100 && !ok; i++) begin
                @(posedge clk);
                ok = (acc_id.size() >= n);
            end
            if (!ok) chk("accept_timeout", 32'd0, 32'd1);
            #1;
        endtask

        task automatic drain();
            bit ok;
            @(posedge clk); #1;
            r0v = 1'b0; r1v = 1'b0; rspr = 1'b1; rst = 1'b0;
            ok = 1'b0;
            for (int i = 0; i < 200 && !ok; i++) begin
                @(posedge clk);
                ok = (sb.size() == 0) && !rv;
            end
            chk("drain", {31'b0, ok}, 32'd1);
        endtask

        task automatic run_random(input int unsigned ops);
            int unsigned target;
            int unsigned k;
            target = nacc + ops;
            k = 0;
            while (nacc < target && k < 40000) begin
                @(posedge clk); #1;
                k++;
                r0v  = ($urandom_range(0, 3) != 0);
                r1v  = ($urandom_range(0, 3) != 0);
                r0a  = W'($urandom); r0b = W'($urandom); r0c = 1'($urandom);
                r1a  = W'($urandom); r1b = W'($urandom); r1c = 1'($urandom);
                if ($urandom_range(0, 7) == 0) begin
                    r0a = '1; r0b = W'(1);
                end
                rspr = ($urandom_range(0, 2) != 0);
                rst  = ($urandom_range(0, 299) == 0);
            end
            chk("random_ops_done", {31'b0, nacc >= target}, 32'd1);
            drain();
        endtask

        if (g == 0) begin : directed
            initial begin
                int unsigned base;
                do_reset();
                @(negedge clk);
                chk("reset_valid", {31'b0, rv}, 32'd0);
                chk("reset_sum", 32'(rs), 32'd0);
                chk("reset_cout", {31'b0, rc}, 32'd0);
                chk("reset_id", {31'b0, rid}, 32'd0);

                rspr = 1'b1;
                issue(1'b0, 16'h1234, 16'h4321, 1'b0);
                wait_rsp(16'h5555, 1'b0, 1'b0);
                issue(1'b1, 16'hFFFF, 16'h0001, 1'b0);
                wait_rsp(16'h0000, 1'b1, 1'b1);
                issue(1'b1, 16'hFFFF, 16'h0000, 1'b1);
                wait_rsp(16'h0000, 1'b1, 1'b1);
                drain();

                // both requesters valid from reset: strict alternation at NIB+2 spacing
                do_reset();
                base = acc_id.size();
                r0v = 1'b1; r0a = 16'h0101; r0b = 16'h0202; r0c = 1'b0;
                r1v = 1'b1; r1a = 16'h1000; r1b = 16'h2000; r1c = 1'b1;
                rspr = 1'b1;
                wait_acc(base + 4);
                r0v = 1'b0; r1v = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (acc_id.size() > base + i) begin
                        chk("t3_order", {31'b0, acc_id[base+i]}, 32'(i % 2));
                        if (i > 0)
                            chk("t3_spacing", acc_edge[base+i] - acc_edge[base+i-1], N + 2);
                    end else begin
                        chk("t3_missing", 32'(i), 32'(base));
                    end
                end
                drain();

                // backpressure in DONE with a competing request pending
                rspr = 1'b0;
                issue(1'b0, 16'h00AA, 16'h0011, 1'b1);
                r1v = 1'b1; r1a = 16'h0005; r1b = 16'h0006; r1c = 1'b0;
                wait_rsp(16'h00BC, 1'b0, 1'b0);
                base = acc_id.size();
                repeat (3) @(negedge clk);
                chk("t4_held_valid", {31'b0, rv}, 32'd1);
                chk("t4_held_sum", 32'(rs), 32'h00BC);
                @(posedge clk); #1 rspr = 1'b1;
                wait_acc(base + 1);
                r1v = 1'b0;
                drain();

                // reset mid-RUN abandons the operation and restores last_grant
                issue(1'b0, 16'h1111, 16'h2222, 1'b0);
                @(posedge clk); #1 rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
                @(negedge clk);
                chk("t5_sum_zero", 32'(rs), 32'd0);
                chk("t5_cout_zero", {31'b0, rc}, 32'd0);
                chk("t5_id_zero", {31'b0, rid}, 32'd0);
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    chk("t5_no_rsp", {31'b0, rv}, 32'd0);
                end
                base = acc_id.size();
                @(posedge clk); #1;
                r0v = 1'b1; r0a = 16'h0F0F; r0b = 16'hF0F1; r0c = 1'b0;
                r1v = 1'b1; r1a = 16'h0001; r1b = 16'h0001; r1c = 1'b0;
                wait_acc(base + 1);
                r0v = 1'b0;
                if (acc_id.size() > base) chk("t5_grant", {31'b0, acc_id[base]}, 32'd0);
                wait_rsp(16'h0000, 1'b1, 1'b0);
                wait_acc(base + 2);
                r1v = 1'b0;
                drain();

                run_random(1000);
                done[g] = 1'b1;
            end
        end else begin : random_only
            initial begin
                do_reset();
                @(negedge clk);
                chk("w4_reset_valid", {31'b0, rv}, 32'd0);
                run_random(1000);
                done[g] = 1'b1;
            end
        end
    end

    initial begin
        for (int i = 0; i < 95000 && done != 2'b11; i++) @(posedge clk);
        chk("finish_timeout", {30'b0, done}, 32'd3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
